// File: rtl/dmarb_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding and requester ids.
package dmarb_pkg;

  typedef logic [1:0] dmarb_state_t;

  localparam dmarb_state_t ST_IDLE   = 2'd0;
  localparam dmarb_state_t ST_ACCESS = 2'd1;
  localparam dmarb_state_t ST_RESP   = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmarb_select.sv
// Winner selection between the two requesters; round-robin pointer only when
// DMARB_ROUND_ROBIN_EN is defined, otherwise port 0 has fixed priority.
module dmarb_select
  import dmarb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant_fire,
  output logic winner,
  output logic any_req
);

  assign any_req = req0 | req1;

`ifdef DMARB_ROUND_ROBIN_EN
  // ptr_q names the port that wins the next tie.
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= PORT0;
    end else if (grant_fire) begin
      ptr_q <= (winner == PORT0) ? PORT1 : PORT0;
    end
  end

  always_comb begin
    winner = PORT0;
    if (req0 && req1) begin
      winner = ptr_q;
    end else if (req1) begin
      winner = PORT1;
    end
  end
`else
  logic unused_sel;
  assign unused_sel = ^{clk, rst_n, grant_fire};

  always_comb begin
    winner = PORT0;
    if (!req0 && req1) begin
      winner = PORT1;
    end
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory, one transaction in flight.
// Optional macro DMARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
//
// state     | meaning
// ST_IDLE   | waiting for a request; grant pulses here
// ST_ACCESS | memory strobe for the latched command, read data captured
// ST_RESP   | rvalid pulse to the winning port
module data_mem_arbiter
  import dmarb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misalign_err
);

  dmarb_state_t      state_q;
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic winner;
  logic any_req;
  logic grant_fire;
  logic in_access;
  logic mis_q;

  dmarb_select u_select (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .grant_fire (grant_fire),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Gate with rst_n so no grant is advertised while reset holds the FSM.
  assign grant_fire = (state_q == ST_IDLE) && any_req && rst_n;
  assign gnt0       = grant_fire && (winner == PORT0);
  assign gnt1       = grant_fire && (winner == PORT1);

  assign in_access = (state_q == ST_ACCESS);
  assign mis_q     = is_misaligned(addr_q[1:0]);
  assign MemRead   = in_access && !we_q;
  assign MemWrite  = in_access && we_q && !mis_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign rvalid0 = (state_q == ST_RESP) && (win_q == PORT0);
  assign rvalid1 = (state_q == ST_RESP) && (win_q == PORT1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_q        <= PORT0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0       <= '0;
      rdata1       <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_fire) begin
            win_q   <= winner;
            we_q    <= (winner == PORT0) ? we0 : we1;
            addr_q  <= (winner == PORT0) ? addr0 : addr1;
            wdata_q <= (winner == PORT0) ? wdata0 : wdata1;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            if (win_q == PORT0) begin
              rdata0 <= mis_q ? '0 : mem_rdata;
            end else begin
              rdata1 <= mis_q ? '0 : mem_rdata;
            end
          end
          if (mis_q) begin
            misalign_err <= 1'b1;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_data_mem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              MemRead, MemWrite;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              misalign_err;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk), .rst_n (rst_n),
    .req0 (req0), .req1 (req1), .we0 (we0), .we1 (we1),
    .addr0 (addr0), .addr1 (addr1), .wdata0 (wdata0), .wdata1 (wdata1),
    .gnt0 (gnt0), .gnt1 (gnt1), .rvalid0 (rvalid0), .rvalid1 (rvalid1),
    .rdata0 (rdata0), .rdata1 (rdata1),
    .MemRead (MemRead), .MemWrite (MemWrite),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT.
  logic [DATA_W-1:0] mem [128];
  assign mem_rdata = mem[mem_addr[ADDR_W-1:2]];
  always @(posedge clk) if (MemWrite) mem[mem_addr[ADDR_W-1:2]] <= mem_wdata;

  logic dual_strobe_seen;
  initial dual_strobe_seen = 1'b0;
  always @(negedge clk) if (MemRead && MemWrite) dual_strobe_seen = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [128];
  logic [DATA_W-1:0] exp_rdata [2];
  logic              exp_err;
  int                exp_ptr;

  // Pending command per requester.
  logic              pend_v [2];
  logic              pend_we [2];
  logic [ADDR_W-1:0] pend_addr [2];
  logic [DATA_W-1:0] pend_wdata [2];

  task automatic drive();
    req0 = pend_v[0]; we0 = pend_we[0]; addr0 = pend_addr[0]; wdata0 = pend_wdata[0];
    req1 = pend_v[1]; we1 = pend_we[1]; addr1 = pend_addr[1]; wdata1 = pend_wdata[1];
  endtask

  task automatic set_cmd(input int p, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pend_v[p] = 1'b1; pend_we[p] = we; pend_addr[p] = a; pend_wdata[p] = d;
  endtask

  task automatic new_cmd(input int p);
    logic [ADDR_W-1:0] a;
    a = {7'($urandom_range(0, 127)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    set_cmd(p, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive();
    @(posedge clk); #1;
    check("rst_gnt", {30'd0, gnt1, gnt0}, 0);
    check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    check("rst_strobes", {30'd0, MemWrite, MemRead}, 0);
    check("rst_err", {31'd0, misalign_err}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_mem_addr", {{(DATA_W-ADDR_W){1'b0}}, mem_addr}, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err = 1'b0; exp_ptr = 0;
  endtask

  // Starts one cycle after a rising edge with the DUT idle; ends likewise.
  task automatic run_txn(input bit refill, input bit abort, output int granted);
    int w;
    logic we, mis;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    drive(); #1;
    if (pend_v[0] && pend_v[1]) begin
`ifdef DMARB_ROUND_ROBIN_EN
      w = exp_ptr;
`else
      w = 0;
`endif
    end else begin
      w = pend_v[1] ? 1 : 0;
    end
    granted = gnt1 ? 1 : 0;
    check("gnt0", {31'd0, gnt0}, {31'd0, w == 0});
    check("gnt1", {31'd0, gnt1}, {31'd0, w == 1});
    exp_ptr = 1 - w;
    we = pend_we[w]; a = pend_addr[w]; d = pend_wdata[w];
    mis = (a[1:0] != 2'b00);

    @(posedge clk); #1;
    pend_v[w] = 1'b0;
    if (refill && $urandom_range(0, 1) == 1) new_cmd(w);
    drive();
    check("mem_read", {31'd0, MemRead}, {31'd0, !we});
    check("mem_write", {31'd0, MemWrite}, {31'd0, we && !mis});
    check("mem_addr", {{(DATA_W-ADDR_W){1'b0}}, mem_addr}, {{(DATA_W-ADDR_W){1'b0}}, a});
    if (we) check("mem_wdata", mem_wdata, d);
    check("gnt_in_access", {30'd0, gnt1, gnt0}, 0);

    if (!abort) begin
      @(posedge clk); #1;
      if (mis) exp_err = 1'b1;
      if (!we) exp_rdata[w] = mis ? '0 : ref_mem[a[ADDR_W-1:2]];
      else if (!mis) ref_mem[a[ADDR_W-1:2]] = d;
      check("rvalid0", {31'd0, rvalid0}, {31'd0, w == 0});
      check("rvalid1", {31'd0, rvalid1}, {31'd0, w == 1});
      check("rdata0", rdata0, exp_rdata[0]);
      check("rdata1", rdata1, exp_rdata[1]);
      check("misalign_err", {31'd0, misalign_err}, {31'd0, exp_err});
      check("gnt_in_resp", {30'd0, gnt1, gnt0}, 0);
      @(posedge clk); #1;
      check("rvalid_idle", {30'd0, rvalid1, rvalid0}, 0);
    end
  endtask

  initial begin
    int g;
    logic [DATA_W-1:0] keep1;
    int exp_seq [4];
    for (int i = 0; i < 128; i++) begin
      logic [DATA_W-1:0] v;
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    for (int p = 0; p < 2; p++) begin
      pend_v[p] = 1'b0; pend_we[p] = 1'b0; pend_addr[p] = '0; pend_wdata[p] = '0;
    end
    exp_ptr = 0;
    rst_n = 1'b0;
    drive();
    @(posedge clk); #1;
    do_reset();

    // Write then read back on port 0.
    set_cmd(0, 1'b1, 9'h010, 32'hDEADBEEF);
    run_txn(0, 0, g);
    set_cmd(0, 1'b0, 9'h010, '0);
    run_txn(0, 0, g);
    check("wr_rd_0x010", rdata0, 32'hDEADBEEF);

    // Port 1 writes, port 0 reads it back.
    keep1 = rdata1;
    set_cmd(1, 1'b1, 9'h004, 32'h55);
    run_txn(0, 0, g);
    set_cmd(0, 1'b0, 9'h004, '0);
    run_txn(0, 0, g);
    check("p1wr_p0rd", rdata0, 32'h00000055);
    check("p1_rdata_kept", rdata1, keep1);

    // Simultaneous reads held for four transactions.
    do_reset();
`ifdef DMARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend_v[p]) set_cmd(p, 1'b0, {7'($urandom_range(0, 127)), 2'b00}, '0);
      run_txn(0, 0, g);
      check("tie_seq", g, exp_seq[k]);
    end
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;

    // Misaligned write on port 1.
    do_reset();
    set_cmd(1, 1'b1, 9'h013, 32'hA5A5A5A5);
    run_txn(0, 0, g);
    check("mis_rdata1", rdata1, 32'h0);
    check("mis_err_set", {31'd0, misalign_err}, 1);
    set_cmd(0, 1'b0, 9'h020, '0);
    run_txn(0, 0, g);
    check("mis_err_sticky", {31'd0, misalign_err}, 1);

    // Reset during the ACCESS cycle of a port 0 read.
    set_cmd(0, 1'b0, 9'h010, '0);
    run_txn(0, 1, g);
    do_reset();
    set_cmd(0, 1'b0, 9'h008, '0);
    set_cmd(1, 1'b0, 9'h00C, '0);
    run_txn(0, 0, g);
    check("post_rst_winner", g, 0);

    // Random traffic.
    for (int it = 0; it < 300; it++) begin
      for (int p = 0; p < 2; p++)
        if (!pend_v[p] && $urandom_range(0, 1) == 1) new_cmd(p);
      if (!pend_v[0] && !pend_v[1]) new_cmd(int'($urandom_range(0, 1)));
      run_txn(1, 0, g);
    end

    check("no_dual_strobe", {31'd0, dual_strobe_seen}, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width matching the data memory addr port.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have ports req0/req1, input, 1, requester 0 (core LSU) / requester 1 (debug/DMA) access request.
REQ-006 SHALL have ports we0/we1, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_W, byte address.
REQ-008 SHALL have ports wdata0/wdata1, input, DATA_W, write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1, one-cycle pulse when the request is accepted.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1, one-cycle completion pulse, for reads and writes.
REQ-011 SHALL have ports rdata0/rdata1, output, DATA_W, read data, valid while rvalidN=1.
REQ-012 SHALL have ports MemRead, MemWrite, output, 1, data memory strobes.
REQ-013 SHALL have ports mem_addr/mem_wdata, output, ADDR_W/DATA_W, memory address and write data.
REQ-014 SHALL have port mem_rdata, input, DATA_W, combinational read data from memory.
REQ-015 SHALL have port misalign_err, output, 1, sticky error flag.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight.
REQ-017 In IDLE with any reqN=1: SHALL pick a winner, pulse gntN that cycle, latch weN/addrN/wdataN and winner id, go to ACCESS.
REQ-018 Requesters SHALL hold reqN and command until gntN; after gntN, a request still high is a new request.
REQ-019 In ACCESS: SHALL drive mem_addr/mem_wdata from the latch, MemRead = !we, MemWrite = we, for exactly one cycle; SHALL register mem_rdata into the winner's rdata; go to RESP.
REQ-020 MemRead and MemWrite SHALL be 0 in all states except ACCESS and SHALL never both be 1.
REQ-021 In RESP: SHALL pulse rvalidN of the winner for one cycle; go to IDLE.
REQ-022 Latency SHALL be gnt at cycle N, memory strobe at N+1, rvalid at N+2; maximum throughput is one transaction per 3 cycles.
REQ-023 rdataN SHALL hold its last value until the next read completion to port N; write completions SHALL NOT modify rdataN.
REQ-024 With addr[1:0] != 0: SHALL still grant and complete, SHALL suppress MemWrite, SHALL return rdata = 0, SHALL set misalign_err until reset.
REQ-025 Requests arriving outside IDLE SHALL NOT be granted until the next IDLE.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, with gnt*, rvalid*, MemRead, MemWrite, misalign_err, rdata*, mem_addr, mem_wdata = 0, and priority pointer = port 0.
REQ-027 Reset in ACCESS or RESP SHALL abort the transaction with no rvalid pulse; a write strobe already issued is not undone.

Configuration
REQ-028 With DMARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the port not granted last, and the pointer SHALL update on each grant.
REQ-029 Without DMARB_ROUND_ROBIN_EN: port 0 SHALL always win simultaneous requests, and there SHALL be no pointer register.

Structure
REQ-030 SHALL place the FSM state typedef (IDLE/ACCESS/RESP) and the port-id constants in shared package dmarb_pkg.
REQ-031 SHALL use one sub-module, dmarb_select, holding the combinational winner selection and the priority pointer.

Verification
REQ-032 Write then read: req0 we0=1 addr0=0x010 wdata0=0xDEADBEEF, then read 0x010 -> gnt0 at N, MemWrite at N+1, rvalid0 at N+2; rdata0=0xDEADBEEF.
REQ-033 Simultaneous reads, req0 and req1 held 4 transactions -> RR: grants alternate 0,1,0,1; fixed: 0,0,0,0 while req0 is held.
REQ-034 Misaligned write addr1=0x013 -> MemWrite never 1, rvalid1 pulses, rdata1=0, misalign_err=1 until rst_n=0.
REQ-035 rst_n=0 in ACCESS of a read -> no rvalid, all outputs 0 next cycle, next grant goes to port 0.
REQ-036 Port 1 write 0x55 to 0x004 then port 0 read 0x004 -> rdata0=0x00000055; rdata1 unchanged.
